pe_bus_rx: RTL and testbench

PE_BUS_RX -- requirements
Module: pe_bus_rx

---
 rtl/pe_bus_pkg.sv | 20 ++
 rtl/pe_pkt_fifo.sv | 51 +++++
 rtl/pe_bus_rx.sv | 127 ++++++++++++
 tb/tb_pe_bus_rx.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_bus_pkg.sv
// Shared types and constants for the PE X-bus receiver.
package pe_bus_pkg;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned PE_DW = 16;

    // Packet at the default operand width; wider instances use a local equivalent.
    typedef struct packed {
        logic [PE_DW-1:0]   ifmap;
        logic [PE_DW-1:0]   fltr;
        logic [2*PE_DW-1:0] psum;
    } pe_pkt_t;

    typedef enum logic [1:0] {
        StIdle,
        StRecv,
        StFlush
    } rx_state_e;

endpackage

// File: rtl/pe_pkt_fifo.sv
// Show-ahead synchronous packet FIFO with synchronous flush.
module pe_pkt_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter type         pkt_t = logic [63:0]
) (
    input  logic clk,
    input  logic rstn,
    input  logic flush,
    input  logic push,
    input  logic pop,
    input  pkt_t wdata,
    output pkt_t rdata,
    output logic full,
    output logic empty
);
    import pe_bus_pkg::*;

    localparam int unsigned AW = $clog2(DEPTH);

    // Extra MSB distinguishes full from empty when the index bits match.
    logic [AW:0] wptr_q;
    logic [AW:0] rptr_q;
    pkt_t        mem [DEPTH];
    logic        push_ok;
    logic        pop_ok;

    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else if (flush) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + (AW+1)'(1);
            if (pop_ok)  rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr_q[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rptr_q[AW-1:0]];
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

endmodule

// File: rtl/pe_bus_rx.sv
// X-bus receiver for one PE: tag match, packet buffering, control FSM and counters.
module pe_bus_rx
    import pe_bus_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_COL    = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       en,
    input  logic                       flush,
    input  logic [$clog2(NUM_COL)-1:0] x_id,
    input  logic [$clog2(NUM_COL)-1:0] x_tag,
    input  logic                       bus_valid,
    output logic                       bus_ready,
    input  logic [DATA_WIDTH-1:0]      ifmap_data_G2B,
    input  logic [DATA_WIDTH-1:0]      fltr_data_G2B,
    input  logic [2*DATA_WIDTH-1:0]    psum_data_G2B,
    output logic                       pe_valid,
    input  logic                       pe_ready,
    output logic [DATA_WIDTH-1:0]      pe_ifmap,
    output logic [DATA_WIDTH-1:0]      pe_fltr,
    output logic [2*DATA_WIDTH-1:0]    pe_psum,
    output logic [CNT_W-1:0]           pkt_cnt,
    output logic [CNT_W-1:0]           drop_cnt
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]   ifmap;
        logic [DATA_WIDTH-1:0]   fltr;
        logic [2*DATA_WIDTH-1:0] psum;
    } pkt_t;

    rx_state_e        state_q;
    rx_state_e        state_d;
    logic             in_flush;
    logic             alive_q;
    logic             full;
    logic             empty;
    logic             tag_hit;
    logic             push;
    logic             pop;
    logic             drop;
    pkt_t             wr_pkt;
    pkt_t             head;
    logic [CNT_W-1:0] pkt_cnt_q;
    logic [CNT_W-1:0] drop_cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = StFlush;
        end else begin
            unique case (state_q)
                StIdle:  state_d = en ? StRecv : StIdle;
                StRecv:  state_d = en ? StRecv : StIdle;
                StFlush: state_d = en ? StRecv : StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        in_flush = (state_q == StFlush);
    end

    // Holds bus_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) alive_q <= 1'b0;
        else       alive_q <= 1'b1;
    end

    assign bus_ready = alive_q && !full && !in_flush;
    assign pe_valid  = !empty && !in_flush;
    assign tag_hit   = bus_valid && en && (x_tag == x_id);
    assign push      = tag_hit && bus_ready && !flush;
    assign pop       = pe_valid && pe_ready && !flush;
    assign drop      = tag_hit && !bus_ready;

    assign wr_pkt = '{ifmap: ifmap_data_G2B, fltr: fltr_data_G2B, psum: psum_data_G2B};

    pe_pkt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .pkt_t (pkt_t)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .wdata (wr_pkt),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        pe_ifmap = '0;
        pe_fltr  = '0;
        pe_psum  = '0;
        if (pe_valid) begin
            pe_ifmap = head.ifmap;
            pe_fltr  = head.fltr;
            pe_psum  = head.psum;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (push && (pkt_cnt_q != '1))  pkt_cnt_q  <= pkt_cnt_q + CNT_W'(1);
            if (drop && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
        end
    end

    assign pkt_cnt  = pkt_cnt_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_pe_bus_rx.sv
// Scenario and randomized checks of pe_bus_rx against a queue-based packet model.
module tb_pe_bus_rx;
    import pe_bus_pkg::*;

    localparam int DW    = 16;
    localparam int NC    = 4;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          en = 1'b0;
    logic          flush = 1'b0;
    logic [1:0]    x_id = 2'd2;
    logic [1:0]    x_tag = 2'd0;
    logic          bus_valid = 1'b0;
    logic          bus_ready;
    logic [DW-1:0]   ifmap_data_G2B = '0;
    logic [DW-1:0]   fltr_data_G2B = '0;
    logic [2*DW-1:0] psum_data_G2B = '0;
    logic          pe_valid;
    logic          pe_ready = 1'b0;
    logic [DW-1:0]   pe_ifmap;
    logic [DW-1:0]   pe_fltr;
    logic [2*DW-1:0] pe_psum;
    logic [15:0]   pkt_cnt;
    logic [15:0]   drop_cnt;

    int n_pass = 0;
    int n_total = 0;

    // Reference model state
    pe_pkt_t m_q[$];
    bit      m_alive = 0;
    bit      m_flush = 0;
    int      m_pkt = 0;
    int      m_drop = 0;

    logic [97:0] act;
    logic [97:0] exp_v;

    pe_bus_rx #(
        .DATA_WIDTH (DW),
        .NUM_COL    (NC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .en             (en),
        .flush          (flush),
        .x_id           (x_id),
        .x_tag          (x_tag),
        .bus_valid      (bus_valid),
        .bus_ready      (bus_ready),
        .ifmap_data_G2B (ifmap_data_G2B),
        .fltr_data_G2B  (fltr_data_G2B),
        .psum_data_G2B  (psum_data_G2B),
        .pe_valid       (pe_valid),
        .pe_ready       (pe_ready),
        .pe_ifmap       (pe_ifmap),
        .pe_fltr        (pe_fltr),
        .pe_psum        (pe_psum),
        .pkt_cnt        (pkt_cnt),
        .drop_cnt       (drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [97:0] dut_vec();
        return {pe_valid, bus_ready, pe_ifmap, pe_fltr, pe_psum, pkt_cnt, drop_cnt};
    endfunction

    function automatic logic [97:0] exp_out();
        bit      pv;
        bit      br;
        pe_pkt_t h;
        pv = (m_q.size() != 0) && !m_flush;
        br = m_alive && (m_q.size() < DEPTH) && !m_flush;
        h  = pv ? m_q[0] : '0;
        return {pv, br, h.ifmap, h.fltr, h.psum, 16'(m_pkt), 16'(m_drop)};
    endfunction

    // Advance one edge with the currently driven inputs and update the model.
    task automatic tick();
        bit      ready;
        bit      pv;
        bit      hit;
        bit      push;
        bit      pop;
        pe_pkt_t w;
        ready = m_alive && (m_q.size() < DEPTH) && !m_flush;
        pv    = (m_q.size() != 0) && !m_flush;
        hit   = bus_valid && en && (x_tag == x_id);
        push  = hit && ready && !flush;
        pop   = pv && pe_ready && !flush;
        w     = '{ifmap: ifmap_data_G2B, fltr: fltr_data_G2B, psum: psum_data_G2B};
        @(posedge clk);
        if (flush) begin
            m_q.delete();
        end else begin
            if (pop)  void'(m_q.pop_front());
            if (push) m_q.push_back(w);
        end
        if (push && m_pkt < 65535) m_pkt++;
        if (hit && !ready && m_drop < 65535) m_drop++;
        m_alive = 1;
        m_flush = flush;
        #1;
    endtask

    task automatic drive_word(input logic [15:0] ifm);
        bus_valid      = 1'b1;
        x_tag          = x_id;
        ifmap_data_G2B = ifm;
        fltr_data_G2B  = 16'($urandom);
        psum_data_G2B  = $urandom;
    endtask

    task automatic model_reset();
        m_q.delete();
        m_alive = 0;
        m_flush = 0;
        m_pkt   = 0;
        m_drop  = 0;
    endtask

    task automatic do_reset();
        en = 1'b0; flush = 1'b0; bus_valid = 1'b0; pe_ready = 1'b0;
        rstn = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        #2;
        act = dut_vec();
        n_total++;
        if (act !== '0) $display("FAIL reset_state: got %h want 0", act);
        else n_pass++;
        do_reset();
        tick();
        n_total++;
        if (bus_ready !== 1'b1) $display("FAIL ready_after_reset: got %b want 1", bus_ready);
        else n_pass++;
        act = dut_vec(); exp_v = exp_out();
        n_total++;
        if (act !== exp_v) $display("FAIL reset_idle_vec: got %h want %h", act, exp_v);
        else n_pass++;
    endtask

    task automatic test_in_order();
        do_reset();
        tick();
        en = 1'b1; pe_ready = 1'b1; x_id = 2'd2;
        for (int k = 1; k <= 3; k++) begin
            drive_word(16'(k));
            tick();
            n_total++;
            if (pe_valid !== 1'b1 || pe_ifmap !== 16'(k))
                $display("FAIL in_order_%0d: got v=%b ifmap=%h want v=1 ifmap=%h",
                         k, pe_valid, pe_ifmap, 16'(k));
            else n_pass++;
            act = dut_vec(); exp_v = exp_out();
            n_total++;
            if (act !== exp_v) $display("FAIL in_order_vec_%0d: got %h want %h", k, act, exp_v);
            else n_pass++;
        end
        bus_valid = 1'b0;
        tick();
        n_total++;
        if (pkt_cnt !== 16'd3 || pe_valid !== 1'b0)
            $display("FAIL in_order_cnt: got cnt=%0d v=%b want cnt=3 v=0", pkt_cnt, pe_valid);
        else n_pass++;
    endtask

    task automatic test_tag_mismatch();
        do_reset();
        tick();
        en = 1'b1; pe_ready = 1'b0; x_id = 2'd2;
        for (int k = 0; k < 5; k++) begin
            drive_word(16'(k + 40));
            x_tag = 2'd1;
            tick();
        end
        bus_valid = 1'b0;
        n_total++;
        if (pe_valid !== 1'b0 || pkt_cnt !== 16'd0 || drop_cnt !== 16'd0)
            $display("FAIL tag_mismatch: got v=%b pkt=%0d drop=%0d want 0/0/0",
                     pe_valid, pkt_cnt, drop_cnt);
        else n_pass++;
    endtask

    task automatic test_overflow();
        do_reset();
        tick();
        en = 1'b1; pe_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            drive_word(16'(10 + k));
            tick();
            act = dut_vec(); exp_v = exp_out();
            n_total++;
            if (act !== exp_v) $display("FAIL overflow_vec_%0d: got %h want %h", k, act, exp_v);
            else n_pass++;
            if (k == 3) begin
                n_total++;
                if (bus_ready !== 1'b0) $display("FAIL full_ready: got %b want 0", bus_ready);
                else n_pass++;
            end
        end
        bus_valid = 1'b0;
        n_total++;
        if (drop_cnt !== 16'd2 || pkt_cnt !== 16'd4)
            $display("FAIL overflow_cnt: got drop=%0d pkt=%0d want 2/4", drop_cnt, pkt_cnt);
        else n_pass++;
        pe_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_total++;
            if (pe_valid !== 1'b1 || pe_ifmap !== 16'(10 + k))
                $display("FAIL drain_%0d: got v=%b ifmap=%h want v=1 ifmap=%h",
                         k, pe_valid, pe_ifmap, 16'(10 + k));
            else n_pass++;
            tick();
        end
        n_total++;
        if (pe_valid !== 1'b0 || pe_ifmap !== 16'd0)
            $display("FAIL drained_empty: got v=%b ifmap=%h want 0/0", pe_valid, pe_ifmap);
        else n_pass++;
    endtask

    task automatic test_flush();
        do_reset();
        tick();
        en = 1'b1; pe_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive_word(16'(20 + k));
            tick();
        end
        drive_word(16'h0099);
        flush = 1'b1;
        tick();
        flush = 1'b0; bus_valid = 1'b0;
        n_total++;
        if (pe_valid !== 1'b0 || bus_ready !== 1'b0 || pkt_cnt !== 16'd2)
            $display("FAIL flush_cycle: got v=%b rdy=%b pkt=%0d want 0/0/2",
                     pe_valid, bus_ready, pkt_cnt);
        else n_pass++;
        tick();
        n_total++;
        if (pe_valid !== 1'b0 || bus_ready !== 1'b1)
            $display("FAIL after_flush: got v=%b rdy=%b want 0/1", pe_valid, bus_ready);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        tick();
        en = 1'b1; pe_ready = 1'b0;
        drive_word(16'd100);
        tick();
        pe_ready = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            drive_word(16'(100 + k));
            tick();
            n_total++;
            if (pe_valid !== 1'b1 || bus_ready !== 1'b1 || pe_ifmap !== 16'(100 + k))
                $display("FAIL b2b_%0d: got v=%b rdy=%b ifmap=%h want 1/1/%h",
                         k, pe_valid, bus_ready, pe_ifmap, 16'(100 + k));
            else n_pass++;
            act = dut_vec(); exp_v = exp_out();
            n_total++;
            if (act !== exp_v) $display("FAIL b2b_vec_%0d: got %h want %h", k, act, exp_v);
            else n_pass++;
        end
        bus_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        tick();
        en = 1'b1; pe_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_word(16'(60 + k));
            tick();
        end
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        n_total++;
        if (pe_valid !== 1'b0 || pkt_cnt !== 16'd0 || drop_cnt !== 16'd0 || bus_ready !== 1'b0)
            $display("FAIL async_reset: got v=%b pkt=%0d drop=%0d rdy=%b want all 0",
                     pe_valid, pkt_cnt, drop_cnt, bus_ready);
        else n_pass++;
        bus_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        tick();
        pe_ready = 1'b1;
        drive_word(16'hABCD);
        tick();
        bus_valid = 1'b0;
        n_total++;
        if (pe_valid !== 1'b1 || pe_ifmap !== 16'hABCD || pkt_cnt !== 16'd1)
            $display("FAIL post_reset_pkt: got v=%b ifmap=%h pkt=%0d want 1/abcd/1",
                     pe_valid, pe_ifmap, pkt_cnt);
        else n_pass++;
        act = dut_vec(); exp_v = exp_out();
        n_total++;
        if (act !== exp_v) $display("FAIL post_reset_vec: got %h want %h", act, exp_v);
        else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        tick();
        for (int c = 0; c < 400; c++) begin
            drive_word(16'($urandom));
            bus_valid = ($urandom_range(0, 3) != 0);
            en        = ($urandom_range(0, 7) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            pe_ready  = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) x_tag = 2'($urandom_range(0, 3));
            tick();
            act = dut_vec(); exp_v = exp_out();
            n_total++;
            if (act !== exp_v) $display("FAIL random_%0d: got %h want %h", c, act, exp_v);
            else n_pass++;
        end
        flush = 1'b0; bus_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_tag_mismatch();
        test_overflow();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
